// File: rtl/resample_pkg.sv
// Shared resample definitions: writer FSM states, group size and the
// position codes exchanged with the display-side resampling reader.
package resample_pkg;

  localparam int WORDS_PER_GRP = 8;

  typedef enum logic [2:0] {
    STATE_IDLE     = 3'd0,
    STATE_CMD      = 3'd1,
    STATE_CMD_WAIT = 3'd2,
    STATE_DTA      = 3'd3,
    STATE_POS      = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    POS_TL = 3'd0,
    POS_TC = 3'd1,
    POS_TR = 3'd2,
    POS_ML = 3'd3,
    POS_MC = 3'd4,
    POS_MR = 3'd5,
    POS_BL = 3'd6,
    POS_BC = 3'd7
  } resample_code_t;

endpackage

// File: rtl/resample_pack.sv
// Resample writer: per group, one position code and eight memory words
// copied to the display fifo, position written after its last word.
module resample_pack #(
  parameter int WORDS_PER_GRP = resample_pkg::WORDS_PER_GRP
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic        rst,
  input  logic        cmd_empty,
  output logic        cmd_rd_en,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_dta,
  input  logic        mem_empty,
  output logic        mem_rd_en,
  input  logic        mem_valid,
  input  logic [63:0] mem_dta,
  input  logic        disp_wr_dta_almost_full,
  output logic        disp_wr_dta_en,
  output logic [63:0] disp_wr_dta,
  input  logic        resample_wr_almost_full,
  output logic        resample_wr_en,
  output logic [2:0]  resample_wr_dta,
  output logic        busy
);
  import resample_pkg::*;

  localparam logic [3:0] GRP_N = 4'(WORDS_PER_GRP);

  state_t      state_q, state_d;
  logic [3:0]  iss_cnt_q, iss_cnt_d;
  logic [3:0]  rcv_cnt_q, rcv_cnt_d;
  logic [3:0]  iss_base, rcv_base;
  logic [2:0]  pos_q, pos_d;
  logic        clr, accept;
  logic        cmd_rd_en_q, cmd_rd_en_d;
  logic        mem_rd_en_q, mem_rd_en_d;
  logic        disp_en_q, disp_en_d;
  logic [63:0] disp_dta_q, disp_dta_d;
  logic        res_en_q, res_en_d;
  logic [2:0]  res_dta_q, res_dta_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    clr     = 1'b0;
    unique case (state_q)
      STATE_IDLE:
        if (~cmd_empty & ~disp_wr_dta_almost_full
            & ~resample_wr_almost_full)
          state_d = STATE_CMD;
      STATE_CMD:
        state_d = STATE_CMD_WAIT;
      STATE_CMD_WAIT:
        if (cmd_valid) begin
          pos_d   = cmd_dta;
          clr     = 1'b1;
          state_d = STATE_DTA;
        end
      STATE_DTA:
        if (rcv_cnt_q == GRP_N)
          state_d = STATE_POS;
      STATE_POS:
        state_d = STATE_IDLE;
      default:
        state_d = STATE_IDLE;
    endcase
  end

  // Strobes are registered, so issue looks at the state being entered.
  always_comb begin
    accept = mem_valid & (state_q == STATE_DTA)
           & (rcv_cnt_q < GRP_N);
    iss_base = clr ? 4'd0 : iss_cnt_q;
    rcv_base = clr ? 4'd0 : rcv_cnt_q;
    mem_rd_en_d = (state_d == STATE_DTA)
                & (iss_base < GRP_N)
                & ~mem_empty
                & ~disp_wr_dta_almost_full;
    iss_cnt_d = iss_base + {3'd0, mem_rd_en_d};
    rcv_cnt_d = rcv_base + {3'd0, accept};
    cmd_rd_en_d = (state_d == STATE_CMD);
    disp_en_d   = accept;
    disp_dta_d  = accept ? mem_dta : disp_dta_q;
    res_en_d    = (state_d == STATE_POS);
    res_dta_d   = res_en_d ? pos_q : res_dta_q;
    busy_d      = (state_d != STATE_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= STATE_IDLE;
      iss_cnt_q   <= 4'd0;
      rcv_cnt_q   <= 4'd0;
      pos_q       <= 3'd0;
      cmd_rd_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      disp_en_q   <= 1'b0;
      disp_dta_q  <= 64'h0;
      res_en_q    <= 1'b0;
      res_dta_q   <= 3'h0;
      busy_q      <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      iss_cnt_q   <= iss_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      pos_q       <= pos_d;
      cmd_rd_en_q <= cmd_rd_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      disp_en_q   <= disp_en_d;
      disp_dta_q  <= disp_dta_d;
      res_en_q    <= res_en_d;
      res_dta_q   <= res_dta_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_rd_en       = cmd_rd_en_q;
  assign mem_rd_en       = mem_rd_en_q;
  assign disp_wr_dta_en  = disp_en_q;
  assign disp_wr_dta     = disp_dta_q;
  assign resample_wr_en  = res_en_q;
  assign resample_wr_dta = res_dta_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_resample_pack.sv
// Bench for resample_pack: fifo models around the writer and a
// scoreboard that expects words in arrival order, then their position.
module tb_resample_pack;
  import resample_pkg::*;

  logic        clk = 1'b0;
  logic        clk_en, rst;
  logic        cmd_empty, cmd_rd_en, cmd_valid;
  logic [2:0]  cmd_dta;
  logic        mem_empty, mem_rd_en, mem_valid;
  logic [63:0] mem_dta;
  logic        disp_af, disp_en;
  logic [63:0] disp_dta;
  logic        res_af, res_en;
  logic [2:0]  res_dta;
  logic        busy;

  resample_pack dut (
    .clk(clk), .clk_en(clk_en), .rst(rst),
    .cmd_empty(cmd_empty), .cmd_rd_en(cmd_rd_en),
    .cmd_valid(cmd_valid), .cmd_dta(cmd_dta),
    .mem_empty(mem_empty), .mem_rd_en(mem_rd_en),
    .mem_valid(mem_valid), .mem_dta(mem_dta),
    .disp_wr_dta_almost_full(disp_af),
    .disp_wr_dta_en(disp_en), .disp_wr_dta(disp_dta),
    .resample_wr_almost_full(res_af),
    .resample_wr_en(res_en), .resample_wr_dta(res_dta),
    .busy(busy)
  );

  always #5 clk = ~clk;

  logic [63:0] mem_arr [256];
  logic [2:0]  cmd_arr [64];
  int cmd_cnt;
  int rd_ptr, cmd_ptr;

  // Source fifos: one cycle read latency, sampled on enabled edges.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid <= 1'b0;
      mem_dta   <= '0;
      cmd_valid <= 1'b0;
      cmd_dta   <= '0;
      cmd_empty <= 1'b1;
      rd_ptr    <= 0;
      cmd_ptr   <= 0;
    end else begin
      if (clk_en) begin
        mem_valid <= mem_rd_en;
        cmd_valid <= cmd_rd_en;
        if (mem_rd_en) begin
          mem_dta <= mem_arr[rd_ptr[7:0]];
          rd_ptr  <= rd_ptr + 1;
        end
        if (cmd_rd_en) begin
          cmd_dta <= cmd_arr[cmd_ptr[5:0]];
          cmd_ptr <= cmd_ptr + 1;
        end
      end
      cmd_empty <= (cmd_ptr + ((clk_en && cmd_rd_en) ? 1 : 0))
                   >= cmd_cnt;
    end
  end

  int n_chk = 0, n_pass = 0;
  int ecyc, n_iss, n_disp, n_pos, n_cmdrd, grp_words;
  int first_word_cyc, last_word_cyc, pos_cyc, first_busy_cyc;
  int exp_ptr, exp_pos;
  bit force_empty, force_af, force_raf;
  bit rnd_stall, rnd_af, rnd_raf, rnd_ce;
  int n0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  tag, obs, exp, $time);
  endtask

  // One sample per enabled cycle: what downstream fifos will latch.
  task automatic mon();
    if (!clk_en) return;
    ecyc++;
    if (busy && first_busy_cyc < 0) first_busy_cyc = ecyc;
    if (mem_rd_en) n_iss++;
    if (cmd_rd_en) n_cmdrd++;
    if (disp_en) begin
      check("disp_word", disp_dta, mem_arr[exp_ptr[7:0]]);
      exp_ptr++;
      grp_words++;
      if (grp_words == 1) first_word_cyc = ecyc;
      last_word_cyc = ecyc;
      n_disp++;
    end
    if (res_en) begin
      check("pos_after_words", 64'(grp_words), 64'(WORDS_PER_GRP));
      check("pos_gap", 64'(ecyc - last_word_cyc), 64'd1);
      check("pos_val", 64'(res_dta), 64'(cmd_arr[exp_pos[5:0]]));
      exp_pos++;
      grp_words = 0;
      n_pos++;
      pos_cyc = ecyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clk_en    = rnd_ce ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_empty = force_empty | (rnd_stall && $urandom_range(0, 2) == 0);
    disp_af   = force_af | (rnd_af && $urandom_range(0, 4) == 0);
    res_af    = force_raf | (rnd_raf && $urandom_range(0, 4) == 0);
    @(negedge clk);
    mon();
  endtask

  // sel: 0 positions, 1 issues, 2 display words
  task automatic run_until(input int sel, input int n, input int budget);
    int k = 0;
    int v;
    v = (sel == 0) ? n_pos : (sel == 1) ? n_iss : n_disp;
    while (v < n && k < budget) begin
      step();
      k++;
      v = (sel == 0) ? n_pos : (sel == 1) ? n_iss : n_disp;
    end
    check("wait_done", 64'(v), 64'(n));
  endtask

  task automatic reset_all();
    rst = 1'b1;
    clk_en = 1'b1;
    force_empty = 0; force_af = 0; force_raf = 0;
    rnd_stall = 0; rnd_af = 0; rnd_raf = 0; rnd_ce = 0;
    mem_empty = 1'b0; disp_af = 1'b0; res_af = 1'b0;
    cmd_cnt = 0;
    ecyc = 0; n_iss = 0; n_disp = 0; n_pos = 0; n_cmdrd = 0;
    grp_words = 0; exp_ptr = 0; exp_pos = 0;
    first_word_cyc = 0; last_word_cyc = 0; pos_cyc = 0;
    first_busy_cyc = -1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic load_rand(input int ngrp);
    for (int i = 0; i < ngrp * 8; i++) mem_arr[i] = {$urandom, $urandom};
    for (int g = 0; g < ngrp; g++) cmd_arr[g] = 3'($urandom_range(0, 7));
    cmd_cnt = ngrp;
  endtask

  task automatic single_group(input bit ce);
    reset_all();
    for (int i = 0; i < 8; i++) mem_arr[i] = 64'(i);
    cmd_arr[0] = 3'd5;
    rnd_ce = ce;
    cmd_cnt = 1;
    run_until(0, 1, 400);
    check("latency", 64'(pos_cyc - first_busy_cyc), 64'd12);
    check("burst", 64'(last_word_cyc - first_word_cyc), 64'd7);
    check("words", 64'(n_disp), 64'd8);
    for (int k = 0; k < 100 && ecyc <= pos_cyc; k++) step();
    check("busy_end", 64'(busy), 64'd0);
  endtask

  initial begin
    clk_en = 1'b1; rst = 1'b0;
    mem_empty = 1'b0; disp_af = 1'b0; res_af = 1'b0;
    cmd_cnt = 0;
    #1 rst = 1'b1;
    #1;
    check("rst_strobes",
          64'({cmd_rd_en, mem_rd_en, disp_en, res_en, busy}), 64'd0);
    check("rst_disp_dta", disp_dta, 64'd0);
    check("rst_res_dta", 64'(res_dta), 64'd0);

    single_group(1'b0);
    single_group(1'b1);

    // Memory starvation after the third issue.
    reset_all();
    load_rand(1);
    run_until(1, 3, 100);
    force_empty = 1; mem_empty = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("starve_no_rd", 64'(mem_rd_en), 64'd0);
    end
    force_empty = 0; mem_empty = 1'b0;
    run_until(0, 1, 100);
    check("starve_words", 64'(n_disp), 64'd8);

    // Display backpressure after word 2 issues.
    reset_all();
    load_rand(1);
    run_until(1, 3, 100);
    force_af = 1; disp_af = 1'b1;
    n0 = n_disp;
    repeat (6) step();
    check("af_inflight_le2", 64'((n_disp - n0) <= 2), 64'd1);
    check("af_no_rd", 64'(mem_rd_en), 64'd0);
    force_af = 0; disp_af = 1'b0;
    run_until(0, 1, 100);
    check("af_words", 64'(n_disp), 64'd8);

    // Resample fifo almost full blocks command reads.
    reset_all();
    load_rand(1);
    force_raf = 1; res_af = 1'b1;
    repeat (20) step();
    check("raf_no_cmd", 64'(n_cmdrd), 64'd0);
    check("raf_idle", 64'(busy), 64'd0);
    force_raf = 0; res_af = 1'b0;
    run_until(0, 1, 100);

    // Back-to-back groups, positions 0..3.
    reset_all();
    for (int i = 0; i < 32; i++) mem_arr[i] = 64'h1000 + 64'(i);
    for (int g = 0; g < 4; g++) cmd_arr[g] = 3'(g);
    cmd_cnt = 4;
    run_until(0, 4, 300);
    check("b2b_words", 64'(n_disp), 64'd32);
    check("b2b_issues", 64'(n_iss), 64'd32);

    // Asynchronous reset mid-group.
    reset_all();
    load_rand(1);
    run_until(2, 4, 100);
    #2 rst = 1'b1;
    #1;
    check("midrst_strobes",
          64'({cmd_rd_en, mem_rd_en, disp_en, res_en, busy}), 64'd0);
    check("midrst_dta", disp_dta, 64'd0);

    // Randomised traffic with stalls, backpressure and clock enable.
    reset_all();
    load_rand(20);
    rnd_stall = 1; rnd_af = 1; rnd_raf = 1; rnd_ce = 1;
    run_until(0, 20, 6000);
    check("rnd_words", 64'(n_disp), 64'd160);
    check("rnd_issues", 64'(n_iss), 64'd160);
    rnd_stall = 0; rnd_af = 0; rnd_raf = 0; rnd_ce = 0;
    repeat (4) step();
    check("rnd_busy_end", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
